// File: rtl/evm_ballot_unit.sv
`default_nettype none
// ============================================================================
// Module      : evm_ballot_unit
// Description : Ballot unit of an electronic voting machine. The presiding
//               officer releases one ballot with the arm button; the voter
//               then selects exactly one candidate. The selection is offered
//               to the counting unit with a valid/ready handshake, followed by
//               a confirmation beep.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   BEEP_CYCLES    : confirmation beep length in clk cycles (1..255)
//   TIMEOUT_CYCLES : armed-ballot lifetime in clk cycles (1..65535)
// Optional feature
//   EVM_BU_TIMEOUT_EN : when defined, an armed ballot expires after
//                       TIMEOUT_CYCLES cycles and pulses timeout; when not
//                       defined, ARMED waits indefinitely and timeout is 0.
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   arm        in   raw ballot-release button (asynchronous)
//   cand_btn   in   raw candidate buttons [3:0] (asynchronous)
//   vote_valid out  vote offered to the counting unit
//   vote_id    out  encoded candidate, valid while vote_valid=1
//   vote_ready in   counting unit accepts the vote
//   ready_led  out  ballot armed, awaiting a voter
//   beep       out  confirmation beep
//   timeout    out  one-cycle pulse when an armed ballot expires
//   ballot_cnt out  accepted votes, wraps 255 -> 0
// ============================================================================
module evm_ballot_unit #(
  parameter int BEEP_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arm,
  input  logic [3:0] cand_btn,
  output logic       vote_valid,
  output logic [1:0] vote_id,
  input  logic       vote_ready,
  output logic       ready_led,
  output logic       beep,
  output logic       timeout,
  output logic [7:0] ballot_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_SEND  = 2'd2,
    S_BEEP  = 2'd3
  } state_t;

  localparam logic [7:0] c_beep_last = 8'(BEEP_CYCLES - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [4:0] r_sync1;
  logic [4:0] r_sync2;
  logic [4:0] r_hist;
  logic [4:0] r_evt;
  logic [3:0] w_cand_evt;
  logic       w_arm_evt;
  logic       w_single;
  logic [1:0] w_enc;
  logic       w_expire;
  logic [7:0] r_beep_cnt;
  logic       r_vote_valid;
  logic [1:0] r_vote_id;
  logic       r_ready_led;
  logic       r_beep;
  logic       r_timeout;
  logic [7:0] r_ballot_cnt;

  // Bit 0 carries arm, bits 4:1 the candidate buttons. The rising-edge
  // detect is registered so a press at edge k shows vote_valid after k+3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_hist  <= '0;
      r_evt   <= '0;
    end else begin
      r_sync1 <= {cand_btn, arm};
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
      r_evt   <= r_sync2 & ~r_hist;
    end
  end

  assign w_arm_evt  = r_evt[0];
  assign w_cand_evt = r_evt[4:1];

  // Exactly one candidate event: non-zero and a power of two.
  assign w_single = (w_cand_evt != 4'd0) &&
                    ((w_cand_evt & (w_cand_evt - 4'd1)) == 4'd0);

  always_comb begin
    w_enc = 2'd0;
    case (w_cand_evt)
      4'b0010: w_enc = 2'd1;
      4'b0100: w_enc = 2'd2;
      4'b1000: w_enc = 2'd3;
      default: w_enc = 2'd0;
    endcase
  end

`ifdef EVM_BU_TIMEOUT_EN
  localparam logic [15:0] c_timer_last = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_timer;

  // Timer is held at zero outside ARMED, so it restarts on every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer <= '0;
    end else if (r_state != S_ARMED) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + 16'd1;
    end
  end

  assign w_expire = (r_state == S_ARMED) && (r_timer == c_timer_last);
`else
  assign w_expire = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_arm_evt) w_state_nxt = S_ARMED;
      // A valid single-button vote takes priority over expiry.
      S_ARMED: if (w_single) w_state_nxt = S_SEND;
               else if (w_expire) w_state_nxt = S_IDLE;
      S_SEND:  if (vote_ready) w_state_nxt = S_BEEP;
      S_BEEP:  if (r_beep_cnt == c_beep_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered decodes of the next state so they track the
  // state register exactly and are cleared asynchronously with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_vote_valid <= 1'b0;
      r_vote_id    <= 2'd0;
      r_ready_led  <= 1'b0;
      r_beep       <= 1'b0;
      r_timeout    <= 1'b0;
      r_ballot_cnt <= 8'd0;
      r_beep_cnt   <= 8'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_vote_valid <= (w_state_nxt == S_SEND);
      r_ready_led  <= (w_state_nxt == S_ARMED);
      r_beep       <= (w_state_nxt == S_BEEP);
      r_timeout    <= (r_state == S_ARMED) && w_expire && !w_single;
      if ((r_state == S_ARMED) && w_single) begin
        r_vote_id <= w_enc;
      end
      if ((r_state == S_SEND) && vote_ready) begin
        r_ballot_cnt <= r_ballot_cnt + 8'd1;
      end
      r_beep_cnt <= (r_state == S_BEEP) ? r_beep_cnt + 8'd1 : 8'd0;
    end
  end

  assign vote_valid = r_vote_valid;
  assign vote_id    = r_vote_id;
  assign ready_led  = r_ready_led;
  assign beep       = r_beep;
  assign timeout    = r_timeout;
  assign ballot_cnt = r_ballot_cnt;

endmodule
`default_nettype wire
